fir_feeder: RTL and testbench

FIR_FEEDER -- requirements
Module: fir_feeder

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_coeff_bank.sv | 50 +++++
 rtl/fir_feeder.sv | 127 ++++++++++++
 tb/tb_fir_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared filter package: FSM encodings and default sizes for the FIR
// datapath and its input feeder.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STUFF = 2'd1,
        ST_FLUSH = 2'd2
    } fir_state_e;

    localparam int FIR_LEN_DEF  = 21;
    localparam int NB_IN_DEF    = 18;
    localparam int NB_COEFF_DEF = 28;
    localparam int OS_DEF       = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register bank: writes only land while the feeder is idle
// and the tap index is in range; anything else pulses an error.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int FIR_LEN  = FIR_LEN_DEF,
    parameter int NB_COEFF = NB_COEFF_DEF,
    parameter int AW       = 5
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        i_idle,
    input  logic                        i_we,
    input  logic [AW-1:0]               i_addr,
    input  logic [NB_COEFF-1:0]         i_wdata,
    output logic [FIR_LEN*NB_COEFF-1:0] o_coeff,
    output logic                        o_coeff_err
);

    localparam logic [AW:0] LEN_W = (AW+1)'(FIR_LEN);

    logic [FIR_LEN*NB_COEFF-1:0] coeff_q, coeff_d;
    logic                        err_q, err_d;
    logic                        wr_ok;

    always_comb begin
        wr_ok   = i_we && i_idle && ({1'b0, i_addr} < LEN_W);
        coeff_d = coeff_q;
        for (int k = 0; k < FIR_LEN; k++) begin
            if (wr_ok && (i_addr == AW'(k))) begin
                coeff_d[k*NB_COEFF +: NB_COEFF] = i_wdata;
            end
        end
        err_d = i_we && !wr_ok;
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            coeff_q <= '0;
            err_q   <= 1'b0;
        end else begin
            coeff_q <= coeff_d;
            err_q   <= err_d;
        end
    end

    assign o_coeff     = coeff_q;
    assign o_coeff_err = err_q;

endmodule

// File: rtl/fir_feeder.sv
// FIR input feeder: zero-stuffing upsampler delay line with flush and
// a write-protected coefficient bank.
module fir_feeder
    import fir_pkg::*;
#(
    parameter int FIR_LEN  = FIR_LEN_DEF,
    parameter int NB_IN    = NB_IN_DEF,
    parameter int NB_COEFF = NB_COEFF_DEF,
    parameter int OS       = OS_DEF,
    localparam int AW      = (FIR_LEN > 1) ? $clog2(FIR_LEN) : 1
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        i_en,
    input  logic [NB_IN-1:0]            i_sample,
    input  logic                        i_sample_valid,
    output logic                        o_sample_ready,
    input  logic                        i_flush,
    input  logic                        i_coeff_we,
    input  logic [AW-1:0]               i_coeff_addr,
    input  logic [NB_COEFF-1:0]         i_coeff_wdata,
    output logic                        o_coeff_err,
    output logic [FIR_LEN*NB_IN-1:0]    o_data_reg,
    output logic [FIR_LEN*NB_COEFF-1:0] o_coeff,
    output logic                        o_valid
);

    localparam int CW = $clog2(max_int(OS, FIR_LEN) + 1);
    localparam logic [CW-1:0] STUFF_LAST = CW'(OS - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FIR_LEN - 1);

    fir_state_e               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [FIR_LEN*NB_IN-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     shift;
    logic [NB_IN-1:0]         shift_in;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        shift    = 1'b0;
        shift_in = '0;
        if (i_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A valid sample wins over a simultaneous flush request
                    if (i_sample_valid) begin
                        shift    = 1'b1;
                        shift_in = i_sample;
                        if (OS > 1) begin
                            state_d = ST_STUFF;
                            cnt_d   = CW'(1);
                        end
                    end else if (i_flush) begin
                        state_d = ST_FLUSH;
                        cnt_d   = '0;
                    end
                end
                ST_STUFF: begin
                    shift = 1'b1;
                    if (cnt_q == STUFF_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    shift = 1'b1;
                    if (cnt_q == FLUSH_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        if (shift) begin
            for (int k = FIR_LEN - 1; k > 0; k--) begin
                data_d[k*NB_IN +: NB_IN] = data_q[(k-1)*NB_IN +: NB_IN];
            end
            data_d[0 +: NB_IN] = shift_in;
        end
        valid_d = shift;
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    fir_coeff_bank #(
        .FIR_LEN  (FIR_LEN),
        .NB_COEFF (NB_COEFF),
        .AW       (AW)
    ) u_coeff_bank (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_idle      (state_q == ST_IDLE),
        .i_we        (i_coeff_we),
        .i_addr      (i_coeff_addr),
        .i_wdata     (i_coeff_wdata),
        .o_coeff     (o_coeff),
        .o_coeff_err (o_coeff_err)
    );

    assign o_sample_ready = i_reset && i_en && (state_q == ST_IDLE);
    assign o_data_reg     = data_q;
    assign o_valid        = valid_q;

endmodule

// File: tb/tb_fir_feeder.sv
// Directed bench for fir_feeder with OS=4, FIR_LEN=21.
module tb_fir_feeder;

    localparam int FIR_LEN  = 21;
    localparam int NB_IN    = 18;
    localparam int NB_COEFF = 28;
    localparam int OS       = 4;
    localparam int AW       = 5;

    logic                        clk = 1'b0;
    logic                        i_reset;
    logic                        i_en;
    logic [NB_IN-1:0]            i_sample;
    logic                        i_sample_valid;
    logic                        o_sample_ready;
    logic                        i_flush;
    logic                        i_coeff_we;
    logic [AW-1:0]               i_coeff_addr;
    logic [NB_COEFF-1:0]         i_coeff_wdata;
    logic                        o_coeff_err;
    logic [FIR_LEN*NB_IN-1:0]    o_data_reg;
    logic [FIR_LEN*NB_COEFF-1:0] o_coeff;
    logic                        o_valid;

    int n_checks = 0;
    int n_err    = 0;
    int vcnt;

    logic [NB_IN-1:0] sym [6];

    fir_feeder #(
        .FIR_LEN  (FIR_LEN),
        .NB_IN    (NB_IN),
        .NB_COEFF (NB_COEFF),
        .OS       (OS)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_en           (i_en),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .i_flush        (i_flush),
        .i_coeff_we     (i_coeff_we),
        .i_coeff_addr   (i_coeff_addr),
        .i_coeff_wdata  (i_coeff_wdata),
        .o_coeff_err    (o_coeff_err),
        .o_data_reg     (o_data_reg),
        .o_coeff        (o_coeff),
        .o_valid        (o_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [NB_IN-1:0] slot(input int k);
        return o_data_reg[k*NB_IN +: NB_IN];
    endfunction

    function automatic logic [NB_COEFF-1:0] tap(input int k);
        return o_coeff[k*NB_COEFF +: NB_COEFF];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        i_reset        = 1'b0;
        i_en           = 1'b0;
        i_sample       = '0;
        i_sample_valid = 1'b0;
        i_flush        = 1'b0;
        i_coeff_we     = 1'b0;
        i_coeff_addr   = '0;
        i_coeff_wdata  = '0;
        for (int i = 0; i < 6; i++) sym[i] = 18'h00100 + 18'(i);

        // reset
        tick();
        tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data_reg === '0), 32'd1);
        chk("rst_coeff", 32'(o_coeff === '0), 32'd1);
        chk("rst_err", 32'(o_coeff_err), 32'd0);
        i_en = 1'b1;
        #1;
        chk("rst_ready_held", 32'(o_sample_ready), 32'd0);
        i_reset = 1'b1;
        #1;
        chk("ready_after_rst", 32'(o_sample_ready), 32'd1);

        // single symbol and its three stuffed zeros
        i_sample       = 18'h08000;
        i_sample_valid = 1'b1;
        tick();
        i_sample_valid = 1'b0;
        chk("acc_valid", 32'(o_valid), 32'd1);
        chk("acc_slot0", 32'(slot(0)), 32'h08000);
        chk("stuff_ready", 32'(o_sample_ready), 32'd0);
        tick();
        chk("stuff1_slot0", 32'(slot(0)), 32'd0);
        chk("stuff1_slot1", 32'(slot(1)), 32'h08000);
        tick();
        chk("stuff2_valid", 32'(o_valid), 32'd1);
        tick();
        chk("stuff3_slot3", 32'(slot(3)), 32'h08000);
        chk("stuff3_valid", 32'(o_valid), 32'd1);
        chk("stuff3_ready", 32'(o_sample_ready), 32'd1);
        tick();
        chk("idle_stall_valid", 32'(o_valid), 32'd0);

        // six back-to-back symbols with valid held high
        i_sample_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_sample = sym[i];
            #1;
            chk("burst_ready", 32'(o_sample_ready), 32'd1);
            tick();
            if (i < 5) begin
                for (int j = 0; j < 3; j++) begin
                    chk("burst_stall", 32'(o_sample_ready), 32'd0);
                    tick();
                end
            end
        end
        i_sample_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("burst_slot", 32'(slot(4 * i)), 32'(sym[5 - i]));
        end
        chk("burst_slot1_zero", 32'(slot(1)), 32'd0);
        tick();
        tick();
        tick();
        chk("burst_idle", 32'(o_sample_ready), 32'd1);

        // flush
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush_enter_valid", 32'(o_valid), 32'd0);
        chk("flush_ready", 32'(o_sample_ready), 32'd0);
        vcnt = 0;
        for (int i = 0; i < FIR_LEN; i++) begin
            tick();
            if (o_valid) vcnt++;
        end
        chk("flush_shifts", 32'(vcnt), 32'd21);
        chk("flush_zero", 32'(o_data_reg === '0), 32'd1);
        chk("flush_idle", 32'(o_sample_ready), 32'd1);
        tick();
        chk("flush_done_valid", 32'(o_valid), 32'd0);

        // flush and valid together: sample wins, flush dropped
        i_sample       = 18'h3ABCD;
        i_sample_valid = 1'b1;
        i_flush        = 1'b1;
        tick();
        i_sample_valid = 1'b0;
        i_flush        = 1'b0;
        chk("prio_slot0", 32'(slot(0)), 32'h3ABCD);
        chk("prio_stuff", 32'(o_sample_ready), 32'd0);
        tick();
        tick();
        tick();
        tick();
        chk("prio_noflush_valid", 32'(o_valid), 32'd0);
        chk("prio_slot3", 32'(slot(3)), 32'h3ABCD);

        // coefficient writes
        i_coeff_we    = 1'b1;
        i_coeff_addr  = 5'd5;
        i_coeff_wdata = 28'h0800000;
        tick();
        i_coeff_we = 1'b0;
        chk("cw_tap5", 32'(tap(5)), 32'h0800000);
        chk("cw_err", 32'(o_coeff_err), 32'd0);
        i_sample       = 18'h00011;
        i_sample_valid = 1'b1;
        tick();
        i_sample_valid = 1'b0;
        i_coeff_we     = 1'b1;
        i_coeff_addr   = 5'd6;
        i_coeff_wdata  = 28'h1234567;
        tick();
        i_coeff_we = 1'b0;
        chk("cw_stuff_err", 32'(o_coeff_err), 32'd1);
        chk("cw_stuff_tap6", 32'(tap(6)), 32'd0);
        tick();
        chk("cw_err_pulse", 32'(o_coeff_err), 32'd0);
        tick();
        i_coeff_we    = 1'b1;
        i_coeff_addr  = 5'd21;
        i_coeff_wdata = 28'hFFFFFFF;
        tick();
        i_coeff_we = 1'b0;
        chk("cw_range_err", 32'(o_coeff_err), 32'd1);
        chk("cw_range_tap5", 32'(tap(5)), 32'h0800000);
        chk("cw_range_tap20", 32'(tap(20)), 32'd0);
        tick();

        // enable drop mid-STUFF
        i_sample       = 18'h00777;
        i_sample_valid = 1'b1;
        tick();
        i_sample_valid = 1'b0;
        tick();
        chk("en_pre_slot1", 32'(slot(1)), 32'h00777);
        i_en = 1'b0;
        #1;
        chk("en_off_ready", 32'(o_sample_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_off_valid", 32'(o_valid), 32'd0);
            chk("en_off_slot1", 32'(slot(1)), 32'h00777);
        end
        i_en = 1'b1;
        tick();
        chk("en_on_slot2", 32'(slot(2)), 32'h00777);
        chk("en_on_valid", 32'(o_valid), 32'd1);
        tick();
        chk("en_on_slot3", 32'(slot(3)), 32'h00777);
        chk("en_on_idle", 32'(o_sample_ready), 32'd1);

        // coefficient write while disabled
        i_en          = 1'b0;
        i_coeff_we    = 1'b1;
        i_coeff_addr  = 5'd0;
        i_coeff_wdata = 28'h0000ABC;
        tick();
        i_coeff_we = 1'b0;
        i_en       = 1'b1;
        chk("cw_en0_tap0", 32'(tap(0)), 32'h0000ABC);

        // reset mid-FLUSH
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("flush_mid_nonzero", 32'(o_data_reg !== '0), 32'd1);
        i_reset = 1'b0;
        tick();
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_data", 32'(o_data_reg === '0), 32'd1);
        chk("mrst_coeff", 32'(o_coeff === '0), 32'd1);
        chk("mrst_err", 32'(o_coeff_err), 32'd0);
        chk("mrst_ready", 32'(o_sample_ready), 32'd0);
        i_reset = 1'b1;
        #1;
        chk("mrst_ready_rel", 32'(o_sample_ready), 32'd1);
        tick();
        chk("mrst_aborted", 32'(o_valid), 32'd0);
        chk("mrst_idle", 32'(o_sample_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
